fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the byte-addressed memory block and drives its request port (address, enable, rw, access_size). It keeps the PC, issues single-word reads, waits out memory busy, and presents each fetched instruction with its PC to decode through a valid/stall handshake. It also supports branch/jump redirects and a run/halt control.

Parameters:
START_PC, 32'h80020000, PC value loaded on reset; equals the memory base address.
ADDR_WIDTH, 32, width of the PC and memory address.
DATA_WIDTH, 32, instruction word width.

Ports:
clock  input  1  single system clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
run  input  1  level; 1 permits new fetch requests.
stall  input  1  decode cannot accept; insn is held while insn_valid && stall.
redirect  input  1  one-cycle pulse; load redirect_pc and squash.
redirect_pc  input  ADDR_WIDTH  redirect target.
mem_busy  input  1  memory busy; the read result is not ready while high.
mem_data  input  DATA_WIDTH  memory data_out; stable until the next read is issued.
mem_address  output  ADDR_WIDTH  read address; equals pc.
mem_enable  output  1  request strobe.
mem_rw  output  1  constant 1 (read).
mem_access_size  output  2  constant 2'b00 (1 word).
insn  output  DATA_WIDTH  fetched instruction.
insn_pc  output  ADDR_WIDTH  address of insn.
insn_valid  output  1  insn/insn_pc hold a valid instruction.
pc  output  ADDR_WIDTH  next fetch address (debug/visibility).

Behaviour:
- Interface: one clock (clock). Reset (reset) is synchronous and active-high.
- On reset:
  - state=IDLE, pc=START_PC.
  - insn=0, insn_pc=0, insn_valid=0.
  - mem_enable=0, mem_rw=1, mem_access_size=2'b00.
- Reset mid-operation discards any in-flight read. The next memory response is ignored because the FSM is in IDLE.
- mem_address is combinational from the pc register. mem_enable=1 only in state ISSUE.
- Consume event: insn_valid && !stall at a rising edge. On a consume with no capture in the same cycle, insn_valid is cleared.
- FSM states:
  - IDLE: mem_enable=0. If run=1, go to ISSUE; else stay.
  - ISSUE: if run=1, drive mem_enable=1 for exactly one cycle, then go to WAIT. If run=0, issue nothing and go to IDLE.
  - WAIT: mem_enable=0; if mem_busy=1, stay. If mem_busy=0 and the output slot is free (!insn_valid, or consume this cycle):
    - capture insn<=mem_data, insn_pc<=pc, insn_valid<=1;
    - update pc<=pc+4;
    - go to ISSUE.
  - WAIT, mem_busy=0 but the slot is not free: go to HOLD without capturing.
  - HOLD: wait until the slot is free, then capture from mem_data (still stable), update pc+=4, and go to ISSUE.
- Latency: the memory result is sampled at the first edge after ISSUE where mem_busy=0. With no busy and no stall, insn_valid rises 2 cycles after ISSUE. Throughput is 1 instruction per 2 cycles.
- Redirect (priority below reset, above everything else):
  - pc<=redirect_pc with bits [1:0] forced to 0; insn_valid<=0.
  - No capture occurs that cycle, even if a capture was due.
  - From WAIT/HOLD/ISSUE the next state is ISSUE, so the in-flight result is dropped. In IDLE, only pc loads and the state stays IDLE.
  - A redirect while mem_busy=1: the FSM goes to ISSUE and the new request waits for the memory. The first WAIT after the new ISSUE samples the new result.
- Run dropped while in WAIT/HOLD: the outstanding read completes and is captured normally. The next ISSUE then goes to IDLE.
- PC arithmetic: ADDR_WIDTH-bit modulo; 32'hFFFFFFFC+4 wraps to 32'h00000000. pc[1:0] is always 2'b00.
- Held outputs: insn and insn_pc never change while insn_valid && stall, except on reset or redirect.

Test Plan:
1. Reset, then run=1, stall=0, mem_busy=0, with memory words 0x8FA20000 @0x80020000 and 0x27BDFFF8 @0x80020004 -> mem_enable pulses with mem_address 0x80020000, then 0x80020004. insn_valid rises 2 cycles after each pulse, with insn/insn_pc=0x8FA20000/0x80020000, then 0x27BDFFF8/0x80020004. pc ends at 0x80020008.
2. mem_busy held high for 3 cycles after the first ISSUE -> the FSM stays in WAIT, and insn_valid rises on the first edge after mem_busy falls, with the correct word. Only one mem_enable pulse occurs.
3. stall=1 for 4 cycles while insn_valid=1 -> insn/insn_pc stay constant and the FSM enters HOLD. After stall falls, the next word is captured one edge later with insn_pc = previous+4. No instruction is lost or duplicated.
4. redirect=1 with redirect_pc=0x80020043 while in WAIT -> insn_valid=0 next cycle and pc=0x80020040. The next mem_address is 0x80020040, and the dropped word never appears on insn.
5. redirect_pc=0xFFFFFFFC, fetch one word -> insn_pc=0xFFFFFFFC and the next mem_address is 0x00000000.
6. run falls while in WAIT -> the pending word is captured, then the FSM goes to IDLE with no further mem_enable. A reset asserted mid-WAIT returns all outputs to their reset values on the next edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-word reads to the byte-addressed
// memory, and hands each fetched word with its PC to decode over a valid/stall handshake.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no request outstanding; waits for run
// ISSUE | drives mem_enable for one cycle when run is high
// WAIT  | read outstanding; waits for mem_busy to fall
// HOLD  | read data ready on mem_data but the output slot is still occupied
module fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] START_PC = 32'h80020000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  mem_busy,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_enable,
  output logic                  mem_rw,
  output logic [1:0]            mem_access_size,
  output logic [DATA_WIDTH-1:0] insn,
  output logic [ADDR_WIDTH-1:0] insn_pc,
  output logic                  insn_valid,
  output logic [ADDR_WIDTH-1:0] pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;
  logic   consume;
  logic   slot_free;
  logic   capture;

  assign consume         = insn_valid && !stall;
  assign slot_free       = !insn_valid || consume;
  assign mem_address     = pc;
  assign mem_rw          = 1'b1;
  assign mem_access_size = 2'b00;

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    mem_enable = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_next = ISSUE;
      end
      ISSUE: begin
        if (run) begin
          mem_enable = 1'b1;
          state_next = WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (!mem_busy) begin
          if (slot_free) begin
            capture    = 1'b1;
            state_next = ISSUE;
          end else begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        // mem_data is stable until the next read, so it can be taken late
        if (slot_free) begin
          capture    = 1'b1;
          state_next = ISSUE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A redirect squashes any due capture and restarts fetch at the new PC
    if (redirect) begin
      capture = 1'b0;
      if (state != IDLE) state_next = ISSUE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= START_PC;
      insn       <= '0;
      insn_pc    <= '0;
      insn_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (redirect) begin
        pc         <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        insn_valid <= 1'b0;
      end else if (capture) begin
        insn       <= mem_data;
        insn_pc    <= pc;
        insn_valid <= 1'b1;
        pc         <= pc + ADDR_WIDTH'(4);
      end else if (consume) begin
        insn_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a small behavioural memory, a cycle table for the
// basic fetch trace, hand-written corner sequences, and a scoreboard of issued reads.
module tb_fetch_unit;

  localparam logic [31:0] START = 32'h80020000;

  logic        clock;
  logic        reset;
  logic        run;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_busy;
  logic [31:0] mem_data;
  logic [31:0] mem_address;
  logic        mem_enable;
  logic        mem_rw;
  logic [1:0]  mem_access_size;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        insn_valid;
  logic [31:0] pc;

  int n_cmp = 0;
  int n_err = 0;
  int busy_lat = 0;
  int busy_cnt = 0;

  fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .START_PC(START)) dut (
    .clock(clock), .reset(reset), .run(run), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_busy(mem_busy), .mem_data(mem_data),
    .mem_address(mem_address), .mem_enable(mem_enable), .mem_rw(mem_rw),
    .mem_access_size(mem_access_size), .insn(insn), .insn_pc(insn_pc),
    .insn_valid(insn_valid), .pc(pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h80020000: return 32'h8FA20000;
      32'h80020004: return 32'h27BDFFF8;
      default:      return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endcase
  endfunction

  // memory: latch the word on a request, then stay busy for busy_lat cycles
  always @(posedge clock) begin
    if (reset) begin
      busy_cnt <= 0;
    end else if (mem_enable) begin
      mem_data <= mem_word(mem_address);
      busy_cnt <= busy_lat;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign mem_busy = (busy_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_enable();
    bit seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (mem_enable) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL timeout_enable: got no mem_enable, wanted one within 50 cycles");
    end
  endtask

  task automatic wait_valid();
    bit seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (insn_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL timeout_valid: got no insn_valid, wanted one within 50 cycles");
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; stall = 1'b0; redirect = 1'b0; busy_lat = 0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // scoreboard: every request is queued at its independently tracked address;
  // whatever is presented on insn must be the oldest unconsumed request
  logic [63:0] sb_q[$];
  logic [31:0] exp_pc = START;
  always @(negedge clock) begin
    if (reset) begin
      sb_q.delete();
      exp_pc = START;
    end else begin
      if (insn_valid) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL sb_empty: got insn_pc %h, wanted no valid insn", insn_pc);
        end else begin
          check("sb_insn", insn, sb_q[0][31:0]);
          check("sb_insn_pc", insn_pc, sb_q[0][63:32]);
          if (!stall && !redirect) void'(sb_q.pop_front());
        end
      end
      if (mem_enable) begin
        check("sb_addr", mem_address, exp_pc);
        sb_q.push_back({exp_pc, mem_word(exp_pc)});
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect) begin
        sb_q.delete();
        exp_pc = {redirect_pc[31:2], 2'b00};
      end
    end
  end

  typedef struct {
    logic        run;
    logic        stall;
    logic        en;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] insn;
    logic [31:0] ipc;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int   en_cnt;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h80020000, 1'b0, 32'h0,        32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h80020000, 1'b0, 32'h0,        32'h0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h80020000, 1'b0, 32'h0,        32'h0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h80020004, 1'b1, 32'h8FA20000, 32'h80020000};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h80020004, 1'b0, 32'h8FA20000, 32'h80020000};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h80020008, 1'b1, 32'h27BDFFF8, 32'h80020004};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h80020008, 1'b0, 32'h27BDFFF8, 32'h80020004};

    reset = 1'b1; run = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) tick();
    @(negedge clock);
    check("rst_enable", 32'(mem_enable), 32'd0);
    check("rst_rw", 32'(mem_rw), 32'd1);
    check("rst_size", 32'(mem_access_size), 32'd0);
    check("rst_valid", 32'(insn_valid), 32'd0);
    check("rst_insn", insn, 32'h0);
    check("rst_insn_pc", insn_pc, 32'h0);
    check("rst_pc", pc, START);
    tick();
    reset = 1'b0;

    // basic two-word fetch trace, cycle by cycle
    for (int i = 0; i < 7; i++) begin
      run = vecs[i].run;
      stall = vecs[i].stall;
      @(negedge clock);
      check($sformatf("t1[%0d] enable", i), 32'(mem_enable), 32'(vecs[i].en));
      check($sformatf("t1[%0d] addr", i), mem_address, vecs[i].addr);
      check($sformatf("t1[%0d] valid", i), 32'(insn_valid), 32'(vecs[i].valid));
      check($sformatf("t1[%0d] insn", i), insn, vecs[i].insn);
      check($sformatf("t1[%0d] insn_pc", i), insn_pc, vecs[i].ipc);
      tick();
    end
    check("t1_pc_end", pc, 32'h80020008);

    // memory busy for 3 cycles after the first request
    do_reset();
    busy_lat = 3;
    run = 1'b1;
    wait_enable();
    en_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clock);
      en_cnt += int'(mem_enable);
      check($sformatf("t2 valid_early[%0d]", k), 32'(insn_valid), 32'd0);
      check($sformatf("t2 busy[%0d]", k), 32'(mem_busy), (k < 3) ? 32'd1 : 32'd0);
    end
    tick();
    @(negedge clock);
    check("t2_valid", 32'(insn_valid), 32'd1);
    check("t2_insn", insn, 32'h8FA20000);
    check("t2_insn_pc", insn_pc, 32'h80020000);
    check("t2_extra_enables", 32'(en_cnt), 32'd0);

    // stall for 4 cycles with a valid instruction held
    do_reset();
    run = 1'b1;
    wait_enable();
    tick();
    stall = 1'b1;
    en_cnt = 0;
    for (int j = 0; j < 4; j++) begin
      tick();
      @(negedge clock);
      en_cnt += int'(mem_enable);
      check($sformatf("t3 hold_valid[%0d]", j), 32'(insn_valid), 32'd1);
      check($sformatf("t3 hold_insn[%0d]", j), insn, 32'h8FA20000);
      check($sformatf("t3 hold_pc[%0d]", j), insn_pc, 32'h80020000);
    end
    tick();
    stall = 1'b0;
    @(negedge clock);
    en_cnt += int'(mem_enable);
    check("t3_release_pc", insn_pc, 32'h80020000);
    tick();
    @(negedge clock);
    check("t3_next_valid", 32'(insn_valid), 32'd1);
    check("t3_next_insn", insn, 32'h27BDFFF8);
    check("t3_next_pc", insn_pc, 32'h80020004);
    check("t3_enables", 32'(en_cnt), 32'd1);

    // redirect while a read is outstanding
    do_reset();
    run = 1'b1;
    wait_enable();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h80020043;
    tick();
    redirect = 1'b0;
    @(negedge clock);
    check("t4_valid", 32'(insn_valid), 32'd0);
    check("t4_pc", pc, 32'h80020040);
    check("t4_enable", 32'(mem_enable), 32'd1);
    check("t4_addr", mem_address, 32'h80020040);
    wait_valid();
    check("t4_insn", insn, mem_word(32'h80020040));
    check("t4_insn_pc", insn_pc, 32'h80020040);

    // redirect from IDLE to the top of the address space, then wrap
    do_reset();
    redirect = 1'b1;
    redirect_pc = 32'hFFFFFFFC;
    tick();
    redirect = 1'b0;
    @(negedge clock);
    check("t5_idle_pc", pc, 32'hFFFFFFFC);
    check("t5_idle_enable", 32'(mem_enable), 32'd0);
    tick();
    run = 1'b1;
    wait_valid();
    check("t5_insn_pc", insn_pc, 32'hFFFFFFFC);
    check("t5_insn", insn, mem_word(32'hFFFFFFFC));
    check("t5_wrap_addr", mem_address, 32'h00000000);
    check("t5_wrap_enable", 32'(mem_enable), 32'd1);
    tick();
    run = 1'b0;

    // run drops during WAIT: pending word still lands, then no more requests
    do_reset();
    run = 1'b1;
    wait_enable();
    tick();
    run = 1'b0;
    tick();
    @(negedge clock);
    check("t6_valid", 32'(insn_valid), 32'd1);
    check("t6_insn_pc", insn_pc, 32'h80020000);
    check("t6_enable", 32'(mem_enable), 32'd0);
    en_cnt = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      @(negedge clock);
      en_cnt += int'(mem_enable);
    end
    check("t6_idle_enables", 32'(en_cnt), 32'd0);
    check("t6_pc", pc, 32'h80020004);

    // reset in the middle of a busy WAIT
    tick();
    busy_lat = 3;
    run = 1'b1;
    wait_enable();
    tick();
    reset = 1'b1;
    run = 1'b0;
    tick();
    @(negedge clock);
    check("t6r_enable", 32'(mem_enable), 32'd0);
    check("t6r_valid", 32'(insn_valid), 32'd0);
    check("t6r_insn", insn, 32'h0);
    check("t6r_insn_pc", insn_pc, 32'h0);
    check("t6r_pc", pc, START);
    tick();
    reset = 1'b0;
    busy_lat = 0;
    en_cnt = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      @(negedge clock);
      en_cnt += int'(mem_enable) + int'(insn_valid);
    end
    check("t6r_quiet", 32'(en_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, wanted finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
